bench_output_scheduler: RTL and testbench

//  Time-shares the single 8-bit io_out pin bus among the 8 benchmark sources (shift reg, seq gen,
//  seq detect, ABRO, BCD, LFSR, traffic, dice). Sources raise req; a round-robin arbiter grants
//  one at a time for a bounded dwell, then inserts a one-cycle gap. A manual mode forces a fixed

---
 rtl/bench_sched_pkg.sv | 32 +++
 rtl/rr_arbiter8.sv | 32 +++
 rtl/bench_output_scheduler.sv | 129 ++++++++++++
 tb/tb_bench_output_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bench_sched_pkg.sv
// Shared types and constants for the benchmark output scheduler.
//   state_t     : scheduler FSM states
//   NUM_SRC     : number of benchmark sources sharing io_out
//   SEL_W       : width of a source index
//   SRC_*       : source index of each benchmark
//   onehot_sel  : index -> one-hot grant vector
package bench_sched_pkg;

  localparam int NUM_SRC = 8;
  localparam int SEL_W   = 3;

  localparam logic [SEL_W-1:0] SRC_SHIFT   = 3'd0;
  localparam logic [SEL_W-1:0] SRC_SEQ_GEN = 3'd1;
  localparam logic [SEL_W-1:0] SRC_SEQ_DET = 3'd2;
  localparam logic [SEL_W-1:0] SRC_ABRO    = 3'd3;
  localparam logic [SEL_W-1:0] SRC_BCD     = 3'd4;
  localparam logic [SEL_W-1:0] SRC_LFSR    = 3'd5;
  localparam logic [SEL_W-1:0] SRC_TRAFFIC = 3'd6;
  localparam logic [SEL_W-1:0] SRC_DICE    = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    GAP    = 2'd2,
    MANUAL = 2'd3
  } state_t;

  function automatic logic [NUM_SRC-1:0] onehot_sel(input logic [SEL_W-1:0] s);
    return NUM_SRC'(1) << s;
  endfunction

endpackage

// File: rtl/rr_arbiter8.sv
// Combinational 8-way round-robin pick.
//   req    : per-source request
//   ptr    : highest-priority index this round
//   any    : at least one request present
//   idx    : winner (first set req bit at ptr, ptr+1, ... wrapping)
//   onehot : winner as one-hot, zero when no request
module rr_arbiter8
  import bench_sched_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx,
  output logic [NUM_SRC-1:0] onehot
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest requester
  // is the last (and therefore winning) assignment.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
    onehot = any ? onehot_sel(idx) : '0;
  end

endmodule

// File: rtl/bench_output_scheduler.sv
// Time-shares the 8-bit io_out bus among the 8 benchmark sources.
// Round-robin grants of up to DWELL cycles, each followed by a one-cycle
// gap; manual mode pins a chosen source onto the bus.
//   clk, reset  : clock, async active-high reset
//   enable      : allow new automatic grants
//   manual      : manual override, manual_sel picks the source
//   req         : per-source request
//   src_data    : source i word at [i*DATA_W +: DATA_W]
//   gnt, sel    : one-hot grant and its index
//   out_data    : registered word of the granted source
//   out_valid   : out_data holds a granted source's word
//   busy        : scheduler not idle
module bench_output_scheduler
  import bench_sched_pkg::*;
#(
  parameter int DWELL  = 4,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      manual,
  input  logic [SEL_W-1:0]          manual_sel,
  input  logic [NUM_SRC-1:0]        req,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        gnt,
  output logic [SEL_W-1:0]          sel,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  output logic                      busy
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  state_t             state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n, sel_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_SRC-1:0] gnt_n;
  logic [DATA_W-1:0]  data_n;
  logic               valid_n;

  logic               arb_any;
  logic [SEL_W-1:0]   arb_idx;
  logic [NUM_SRC-1:0] arb_onehot;

  rr_arbiter8 u_arb (
    .req    (req),
    .ptr    (ptr),
    .any    (arb_any),
    .idx    (arb_idx),
    .onehot (arb_onehot)
  );

  logic [DATA_W-1:0] sel_word, man_word;
  assign sel_word = src_data[sel*DATA_W +: DATA_W];
  assign man_word = src_data[manual_sel*DATA_W +: DATA_W];

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = gnt;
    sel_n   = sel;
    data_n  = out_data;
    valid_n = out_valid;

    if (state != HOLD && state != MANUAL && !manual && enable && arb_any) begin
      // New automatic grant out of IDLE or GAP; data follows a cycle later.
      state_n = HOLD;
      gnt_n   = arb_onehot;
      sel_n   = arb_idx;
      ptr_n   = arb_idx + SEL_W'(1);
      cnt_n   = '0;
    end else if (manual) begin
      // Override from any state; re-evaluated every edge so manual_sel
      // changes land with one cycle of lag.
      state_n = MANUAL;
      gnt_n   = onehot_sel(manual_sel);
      sel_n   = manual_sel;
      data_n  = man_word;
      valid_n = 1'b1;
    end else begin
      case (state)
        HOLD: begin
          data_n = sel_word;
          if (cnt == CNT_LAST || !req[sel]) begin
            state_n = GAP;
            gnt_n   = '0;
            valid_n = 1'b0;
          end else begin
            cnt_n   = cnt + CNT_W'(1);
            valid_n = 1'b1;
          end
        end
        MANUAL: begin
          state_n = GAP;
          gnt_n   = '0;
          valid_n = 1'b0;
        end
        GAP:     state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      sel       <= sel_n;
      out_data  <= data_n;
      out_valid <= valid_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bench_output_scheduler.sv
// Directed bench for bench_output_scheduler (DWELL=4, DATA_W=8).
// Source i drives the constant word 8'hA0+i. Observed tuple per check is
// {gnt, sel, out_valid, busy, out_data}.
module tb_bench_output_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        manual = 1'b0;
  logic [2:0]  manual_sel = 3'd0;
  logic [7:0]  req = 8'h00;
  logic [63:0] src_data;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [20:0] obs;
  assign obs = {gnt, sel, out_valid, busy, out_data};

  always #5 clk = ~clk;

  bench_output_scheduler #(.DWELL(4), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .manual     (manual),
    .manual_sel (manual_sel),
    .req        (req),
    .src_data   (src_data),
    .gnt        (gnt),
    .sel        (sel),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    for (int i = 0; i < 8; i++) src_data[i*8 +: 8] = 8'hA0 + 8'(i);
    reset = 1'b1; enable = 1'b1; req = 8'h00;
    step(); step();
    reset = 1'b0;
    exp = {8'h00, 3'd0, 1'b0, 1'b0, 8'h00};
    n_cmp++;
    if (obs !== exp) begin n_bad++; $display("FAIL reset_state: got %h expected %h", obs, exp); end
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (obs !== exp) begin n_bad++; $display("FAIL idle_no_req cyc%0d: got %h expected %h", i, obs, exp); end
    end
  endtask

  task automatic test_round_robin();
    logic [20:0] exp_t [12];
    exp_t[0]  = {8'h01, 3'd0, 1'b0, 1'b1, 8'h00};
    exp_t[1]  = {8'h01, 3'd0, 1'b1, 1'b1, 8'hA0};
    exp_t[2]  = {8'h01, 3'd0, 1'b1, 1'b1, 8'hA0};
    exp_t[3]  = {8'h01, 3'd0, 1'b1, 1'b1, 8'hA0};
    exp_t[4]  = {8'h00, 3'd0, 1'b0, 1'b1, 8'hA0};
    exp_t[5]  = {8'h80, 3'd7, 1'b0, 1'b1, 8'hA0};
    exp_t[6]  = {8'h80, 3'd7, 1'b1, 1'b1, 8'hA7};
    exp_t[7]  = {8'h80, 3'd7, 1'b1, 1'b1, 8'hA7};
    exp_t[8]  = {8'h80, 3'd7, 1'b1, 1'b1, 8'hA7};
    exp_t[9]  = {8'h00, 3'd7, 1'b0, 1'b1, 8'hA7};
    exp_t[10] = {8'h01, 3'd0, 1'b0, 1'b1, 8'hA7};
    exp_t[11] = {8'h01, 3'd0, 1'b1, 1'b1, 8'hA0};
    req = 8'h81;
    for (int i = 0; i < 12; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_t[i]) begin n_bad++; $display("FAIL rr_81 step%0d: got %h expected %h", i, obs, exp_t[i]); end
    end
    // Drop requests: early release to GAP, then IDLE (ptr now 1).
    req = 8'h00;
    step();
    n_cmp++;
    if (obs !== {8'h00, 3'd0, 1'b0, 1'b1, 8'hA0}) begin n_bad++; $display("FAIL rr_drain_gap: got %h expected %h", obs, {8'h00, 3'd0, 1'b0, 1'b1, 8'hA0}); end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rr_drain_idle busy: got %b expected 0", busy); end
  endtask

  task automatic test_early_release();
    req = 8'h04;
    step();
    n_cmp++;
    if (obs !== {8'h04, 3'd2, 1'b0, 1'b1, 8'hA0}) begin n_bad++; $display("FAIL rel_grant: got %h expected %h", obs, {8'h04, 3'd2, 1'b0, 1'b1, 8'hA0}); end
    step();
    n_cmp++;
    if (obs !== {8'h04, 3'd2, 1'b1, 1'b1, 8'hA2}) begin n_bad++; $display("FAIL rel_hold2: got %h expected %h", obs, {8'h04, 3'd2, 1'b1, 1'b1, 8'hA2}); end
    req = 8'h00;
    step();
    n_cmp++;
    if (obs !== {8'h00, 3'd2, 1'b0, 1'b1, 8'hA2}) begin n_bad++; $display("FAIL rel_gap: got %h expected %h", obs, {8'h00, 3'd2, 1'b0, 1'b1, 8'hA2}); end
    step();
    n_cmp++;
    if (obs !== {8'h00, 3'd2, 1'b0, 1'b0, 8'hA2}) begin n_bad++; $display("FAIL rel_idle: got %h expected %h", obs, {8'h00, 3'd2, 1'b0, 1'b0, 8'hA2}); end
  endtask

  task automatic test_manual();
    // ptr is 3, so a lone req[5] wins and leaves ptr at 6.
    req = 8'h20;
    step();
    n_cmp++;
    if (obs !== {8'h20, 3'd5, 1'b0, 1'b1, 8'hA2}) begin n_bad++; $display("FAIL man_hold5: got %h expected %h", obs, {8'h20, 3'd5, 1'b0, 1'b1, 8'hA2}); end
    manual = 1'b1; manual_sel = 3'd3;
    step();
    n_cmp++;
    if (obs !== {8'h08, 3'd3, 1'b1, 1'b1, 8'hA3}) begin n_bad++; $display("FAIL man_sel3: got %h expected %h", obs, {8'h08, 3'd3, 1'b1, 1'b1, 8'hA3}); end
    manual_sel = 3'd1;
    step();
    n_cmp++;
    if (obs !== {8'h02, 3'd1, 1'b1, 1'b1, 8'hA1}) begin n_bad++; $display("FAIL man_sel1: got %h expected %h", obs, {8'h02, 3'd1, 1'b1, 1'b1, 8'hA1}); end
    manual = 1'b0; req = 8'hFF;
    step();
    n_cmp++;
    if (obs !== {8'h00, 3'd1, 1'b0, 1'b1, 8'hA1}) begin n_bad++; $display("FAIL man_exit_gap: got %h expected %h", obs, {8'h00, 3'd1, 1'b0, 1'b1, 8'hA1}); end
    step();
    n_cmp++;
    if (obs !== {8'h40, 3'd6, 1'b0, 1'b1, 8'hA1}) begin n_bad++; $display("FAIL man_resume_ptr6: got %h expected %h", obs, {8'h40, 3'd6, 1'b0, 1'b1, 8'hA1}); end
    req = 8'h00;
    step(); step();
    n_cmp++;
    if (obs !== {8'h00, 3'd6, 1'b0, 1'b0, 8'hA6}) begin n_bad++; $display("FAIL man_drain_idle: got %h expected %h", obs, {8'h00, 3'd6, 1'b0, 1'b0, 8'hA6}); end
  endtask

  task automatic test_enable_drop();
    // ptr is 7: grant wraps through source 7.
    req = 8'hFF;
    step();
    n_cmp++;
    if (obs !== {8'h80, 3'd7, 1'b0, 1'b1, 8'hA6}) begin n_bad++; $display("FAIL en_grant7: got %h expected %h", obs, {8'h80, 3'd7, 1'b0, 1'b1, 8'hA6}); end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== {8'h80, 3'd7, 1'b1, 1'b1, 8'hA7}) begin n_bad++; $display("FAIL en_runout%0d: got %h expected %h", i, obs, {8'h80, 3'd7, 1'b1, 1'b1, 8'hA7}); end
    end
    step();
    n_cmp++;
    if (obs !== {8'h00, 3'd7, 1'b0, 1'b1, 8'hA7}) begin n_bad++; $display("FAIL en_gap: got %h expected %h", obs, {8'h00, 3'd7, 1'b0, 1'b1, 8'hA7}); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs !== {8'h00, 3'd7, 1'b0, 1'b0, 8'hA7}) begin n_bad++; $display("FAIL en_idle%0d: got %h expected %h", i, obs, {8'h00, 3'd7, 1'b0, 1'b0, 8'hA7}); end
    end
  endtask

  task automatic test_reset_mid_hold();
    // ptr is 0: source 0 wins, ptr moves to 1.
    enable = 1'b1; req = 8'hFF;
    step();
    step();
    n_cmp++;
    if (obs !== {8'h01, 3'd0, 1'b1, 1'b1, 8'hA0}) begin n_bad++; $display("FAIL rst_pre_hold: got %h expected %h", obs, {8'h01, 3'd0, 1'b1, 1'b1, 8'hA0}); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== 21'h0) begin n_bad++; $display("FAIL rst_async_clear: got %h expected %h", obs, 21'h0); end
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if (obs !== {8'h01, 3'd0, 1'b0, 1'b1, 8'h00}) begin n_bad++; $display("FAIL rst_first_grant0: got %h expected %h", obs, {8'h01, 3'd0, 1'b0, 1'b1, 8'h00}); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_early_release();
    test_manual();
    test_enable_drop();
    test_reset_mid_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
